// File: rtl/player_tank_state.sv
// Registered per-player tank state: commits position/facing per frame, owns fire cooldown,
// the bullet-spawn request handshake and the alive/dying/respawn/dead lifecycle.
module player_tank_state #(
  parameter int SPAWN_X       = 320,
  parameter int SPAWN_Y       = 400,
  parameter int X_MAX         = 624,
  parameter int Y_MAX         = 464,
  parameter int TANK_SIZE     = 16,
  parameter int FIRE_COOLDOWN = 30,
  parameter int DIE_FRAMES    = 32,
  parameter int INVULN_FRAMES = 60,
  parameter int LIVES_INIT    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       move_req,
  input  logic [1:0] dir_in,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       fire,
  input  logic       blocked,
  input  logic       hit,
  input  logic       bullet_ack,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic       bullet_req,
  output logic [9:0] bullet_x,
  output logic [9:0] bullet_y,
  output logic [1:0] bullet_dir
);

  localparam logic [1:0] ST_DEAD    = 2'b00;
  localparam logic [1:0] ST_ALIVE   = 2'b01;
  localparam logic [1:0] ST_DYING   = 2'b10;
  localparam logic [1:0] ST_RESPAWN = 2'b11;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [9:0] XMAX    = 10'(X_MAX);
  localparam logic [9:0] YMAX    = 10'(Y_MAX);
  localparam logic [9:0] SX      = 10'(SPAWN_X);
  localparam logic [9:0] SY      = 10'(SPAWN_Y);
  localparam logic [9:0] HALF    = 10'(TANK_SIZE / 2);
  localparam logic [7:0] CD_LOAD = 8'(FIRE_COOLDOWN);
  localparam logic [7:0] DIE_END = 8'(DIE_FRAMES - 1);
  localparam logic [7:0] INV_END = 8'(INVULN_FRAMES - 1);

  logic [7:0] cooldown;
  logic [7:0] cd_next;
  logic [7:0] frame_cnt;
  logic [9:0] clamp_x;
  logic [9:0] clamp_y;
  logic       can_act;
  logic       fire_ok;

  // Out-of-range values wrap through zero, so the direction tells underflow from overflow.
  always_comb begin
    clamp_x = next_x;
    clamp_y = next_y;
    if (next_x > XMAX) begin
      if (dir_in == DIR_LEFT)  clamp_x = '0;
      if (dir_in == DIR_RIGHT) clamp_x = XMAX;
    end
    if (next_y > YMAX) begin
      if (dir_in == DIR_UP)   clamp_y = '0;
      if (dir_in == DIR_DOWN) clamp_y = YMAX;
    end
  end

  // Fire is judged on the post-decrement cooldown so shots land FIRE_COOLDOWN frames apart.
  assign cd_next = (cooldown != '0) ? cooldown - 8'd1 : '0;
  assign can_act = ((state == ST_ALIVE) && !hit) || (state == ST_RESPAWN);
  assign fire_ok = frame_tick && can_act && fire && (cd_next == '0) && !bullet_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x      <= SX;
      pos_y      <= SY;
      dir        <= DIR_UP;
      state      <= ST_ALIVE;
      lives      <= 2'(LIVES_INIT);
      bullet_req <= 1'b0;
      bullet_x   <= '0;
      bullet_y   <= '0;
      bullet_dir <= '0;
      cooldown   <= '0;
      frame_cnt  <= '0;
    end else begin
      if (bullet_req && bullet_ack) bullet_req <= 1'b0;
      if (fire_ok) begin
        bullet_req <= 1'b1;
        bullet_x   <= pos_x + HALF;
        bullet_y   <= pos_y + HALF;
        bullet_dir <= dir;
      end

      if (frame_tick && (state != ST_DEAD)) cooldown <= fire_ok ? CD_LOAD : cd_next;

      if (frame_tick && can_act && move_req) begin
        dir <= dir_in;
        if (!blocked) begin
          pos_x <= clamp_x;
          pos_y <= clamp_y;
        end
      end

      case (state)
        ST_ALIVE: begin
          if (hit) begin
            state     <= ST_DYING;
            lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
            frame_cnt <= '0;
          end
        end
        ST_DYING: begin
          if (frame_tick) begin
            if (frame_cnt == DIE_END) begin
              frame_cnt <= '0;
              if (lives == 2'd0) begin
                state <= ST_DEAD;
              end else begin
                state    <= ST_RESPAWN;
                pos_x    <= SX;
                pos_y    <= SY;
                dir      <= DIR_UP;
                cooldown <= '0;
              end
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        ST_RESPAWN: begin
          if (frame_tick) begin
            if (frame_cnt == INV_END) begin
              frame_cnt <= '0;
              state     <= ST_ALIVE;
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
